// File: rtl/motion_sequencer.sv
// Command-level motion controller in front of motor_driver: accepts timed motion
// commands and plays each one as soft-start ramp, timed run, soft-stop ramp and dead time.
module motion_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int RAMP_STEP  = 8,
    parameter int PERIOD     = 1000,
    parameter int DEAD_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_dir,
    input  logic [7:0]  cmd_speed,
    input  logic [15:0] cmd_duration,
    input  logic        estop,
    output logic [2:0]  motor_out,
    output logic [31:0] period,
    output logic [31:0] duty_cycle,
    output logic        busy,
    output logic        done
);
    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [8:0]       STEP9    = 9'(RAMP_STEP);
    localparam logic [7:0]       STEP8    = 8'(RAMP_STEP);
    localparam logic [15:0]      DEAD_CNT = 16'(DEAD_TICKS);
    localparam logic [31:0]      PERIOD_W = 32'(PERIOD);
    localparam logic [2:0]       DIR_STOP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEL, S_RUN, S_DECEL, S_DEAD, S_PAUSE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       cur_dir_q, cur_dir_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       cur_speed_q, cur_speed_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       motor_out_q, motor_out_d;
    logic [31:0]      duty_q, duty_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic [8:0]       speed_up;
    logic [31:0]      duty_full;
    logic             motion;

    // Free-running prescaler; only reset clears it, so tick phase is independent of commands.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_ONE;
    end

    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        target_d    = target_q;
        cur_speed_d = cur_speed_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        speed_up    = {1'b0, cur_speed_q} + STEP9;
        if (estop) begin
            state_d     = S_DEAD;
            cur_speed_d = 8'd0;
            cnt_d       = DEAD_CNT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cur_dir_d = cmd_dir;
                        target_d  = cmd_speed;
                        cnt_d     = cmd_duration;
                        state_d   = (cmd_dir < DIR_STOP) ? S_ACCEL : S_PAUSE;
                    end
                end
                S_ACCEL: begin
                    if (cur_speed_q == target_q) begin
                        state_d = S_RUN;
                    end else if (tick) begin
                        cur_speed_d = (speed_up > {1'b0, target_q}) ? target_q : speed_up[7:0];
                    end
                end
                S_RUN: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_DECEL;
                    end else if (tick) begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_DECEL: begin
                    if (cur_speed_q == 8'd0) begin
                        state_d = S_DEAD;
                        cnt_d   = DEAD_CNT;
                    end else if (tick) begin
                        cur_speed_d = (cur_speed_q > STEP8) ? cur_speed_q - STEP8 : 8'd0;
                    end
                end
                S_DEAD, S_PAUSE: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (tick) begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // estop forces stop values on the very next edge rather than waiting for the state to settle.
    always_comb begin
        cmd_ready   = (state_q == S_IDLE) && !estop && !rst;
        motion      = (state_q == S_ACCEL || state_q == S_RUN || state_q == S_DECEL) && !estop;
        motor_out_d = motion ? cur_dir_q : DIR_STOP;
        duty_full   = PERIOD_W * {24'd0, cur_speed_q};
        duty_d      = motion ? {8'd0, duty_full[31:8]} : 32'd0;
        busy_d      = (state_q != S_IDLE) || estop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cur_dir_q   <= DIR_STOP;
            target_q    <= 8'd0;
            cur_speed_q <= 8'd0;
            cnt_q       <= 16'd0;
            motor_out_q <= DIR_STOP;
            duty_q      <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cur_dir_q   <= cur_dir_d;
            target_q    <= target_d;
            cur_speed_q <= cur_speed_d;
            cnt_q       <= cnt_d;
            motor_out_q <= motor_out_d;
            duty_q      <= duty_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign motor_out  = motor_out_q;
    assign period     = PERIOD_W;
    assign duty_cycle = duty_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with TICK_DIV=4, RAMP_STEP=64, PERIOD=1000, DEAD_TICKS=2;
// outputs are run-length recorded per command and compared with hand-computed sequences.
module tb_motion_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_dir;
    logic [7:0]  cmd_speed;
    logic [15:0] cmd_duration;
    logic        estop;
    logic [2:0]  motor_out;
    logic [31:0] period;
    logic [31:0] duty_cycle;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    motion_sequencer #(
        .TICK_DIV(4), .RAMP_STEP(64), .PERIOD(1000), .DEAD_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_speed(cmd_speed), .cmd_duration(cmd_duration),
        .estop(estop), .motor_out(motor_out), .period(period),
        .duty_cycle(duty_cycle), .busy(busy), .done(done)
    );

    int chk_total = 0;
    int chk_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act !== exp) begin
            chk_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Run-length records of motor_out and duty_cycle from the cycle after accept up to done.
    int   m_val[16], m_len[16], m_n;
    int   d_val[16], d_len[16], d_n;
    int   done_i;
    logic b1, b2, rdy_done;

    task automatic watch(input int budget);
        m_n = 0; d_n = 0; done_i = 0; b1 = 1'b0; b2 = 1'b0; rdy_done = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) b1 = busy;
            if (i == 2) b2 = busy;
            if (done) begin
                done_i   = i;
                rdy_done = cmd_ready;
                break;
            end
            if (m_n > 0 && m_val[m_n-1] == int'(motor_out)) m_len[m_n-1]++;
            else if (m_n < 16) begin m_val[m_n] = int'(motor_out); m_len[m_n] = 1; m_n++; end
            if (d_n > 0 && d_val[d_n-1] == int'(duty_cycle)) d_len[d_n-1]++;
            else if (d_n < 16) begin d_val[d_n] = int'(duty_cycle); d_len[d_n] = 1; d_n++; end
        end
        check("watch_done_seen", (done_i != 0), 1'b1);
    endtask

    task automatic send(input logic [2:0] dir, input logic [7:0] spd, input logic [15:0] dur);
        int w;
        cmd_dir = dir; cmd_speed = spd; cmd_duration = dur; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        check("send_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        $display("cmd dir=%0d speed=%0d duration=%0d accepted at %0t", dir, spd, dur, $time);
    endtask

    int exp_fwd[9]     = '{0, 250, 500, 750, 781, 531, 281, 31, 0};
    int exp_fwd_len[9] = '{0, 4, 4, 4, 16, 4, 4, 4, 8};
    int exp_rev[5]     = '{0, 250, 500, 250, 0};
    int exp_rev_len[5] = '{0, 4, 8, 4, 8};

    initial begin
        int tail, w, n_done, n_bad;
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 3'd0; cmd_speed = 8'd0;
        cmd_duration = 16'd0; estop = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_motor_out", motor_out, 4);
        check("rst_duty", duty_cycle, 0);
        check("rst_period", period, 1000);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        #1 check("rst_release_ready", cmd_ready, 1);

        // Forward ramp/run/ramp/dead
        send(3'd0, 8'd200, 16'd3);
        watch(400);
        check("fwd_busy_c1", b1, 0);
        check("fwd_busy_c2", b2, 1);
        check("fwd_m_segs", m_n, 3);
        check("fwd_m0_val", m_val[0], 4);
        check("fwd_m0_len", m_len[0], 1);
        check("fwd_m1_val", m_val[1], 0);
        check("fwd_m2_val", m_val[2], 4);
        check("fwd_dead_len", m_len[2], 7);
        check("fwd_d_segs", d_n, 9);
        for (int k = 0; k < 9; k++) check($sformatf("fwd_duty%0d", k), d_val[k], exp_fwd[k]);
        for (int k = 1; k < 9; k++) check($sformatf("fwd_len%0d", k), d_len[k], exp_fwd_len[k]);
        check("fwd_ready_at_done", rdy_done, 1);
        @(negedge clk);
        check("fwd_done_one_cycle", done, 0);

        // Reversal, second command back-to-back on the done cycle
        send(3'd0, 8'd128, 16'd1);
        watch(400);
        tail = m_len[m_n-1];
        check("rev1_m1_val", m_val[1], 0);
        check("rev1_d_segs", d_n, 5);
        for (int k = 0; k < 5; k++) check($sformatf("rev1_duty%0d", k), d_val[k], exp_rev[k]);
        for (int k = 1; k < 5; k++) check($sformatf("rev1_len%0d", k), d_len[k], exp_rev_len[k]);
        check("rev_duty_at_done", duty_cycle, 0);
        send(3'd3, 8'd128, 16'd1);
        watch(400);
        check("rev2_m0_val", m_val[0], 4);
        check("rev2_m1_val", m_val[1], 3);
        check("rev_stop_gap", tail + 1 + m_len[0], 9);
        check("rev2_duty0", d_val[0], 0);
        check("rev2_duty_peak", d_val[2], 500);

        // Pause: timed stop, no dead time
        send(3'd5, 8'd100, 16'd2);
        watch(100);
        check("pause_m_segs", m_n, 1);
        check("pause_m_val", m_val[0], 4);
        check("pause_d_segs", d_n, 1);
        check("pause_d_val", d_val[0], 0);
        check("pause_busy_c2", b2, 1);
        check("pause_done_in_7_10", (done_i >= 7 && done_i <= 10), 1'b1);

        // Emergency stop mid-run
        send(3'd0, 8'd255, 16'd50);
        w = 0;
        while (duty_cycle != 32'd996 && w < 100) begin @(negedge clk); w++; end
        check("estop_run_duty", duty_cycle, 996);
        estop = 1'b1;
        #1 check("estop_ready_comb", cmd_ready, 0);
        @(negedge clk);
        check("estop_motor", motor_out, 4);
        check("estop_duty", duty_cycle, 0);
        check("estop_busy", busy, 1);
        n_done = 0; n_bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (done) n_done++;
            if (motor_out != 3'd4 || cmd_ready) n_bad++;
        end
        check("estop_hold_done", n_done, 0);
        check("estop_hold_stop", n_bad, 0);
        estop = 1'b0;
        watch(100);
        check("estop_rel_m_segs", m_n, 1);
        check("estop_rel_done_in_6_9", (done_i >= 6 && done_i <= 9), 1'b1);
        check("estop_rel_ready", rdy_done, 1);
        repeat (5) @(negedge clk);
        check("estop_dropped_busy", busy, 0);
        check("estop_dropped_motor", motor_out, 4);

        // Speed 0 / duration 0, offered while a pause is still busy
        send(3'd5, 8'd0, 16'd3);
        cmd_dir = 3'd1; cmd_speed = 8'd0; cmd_duration = 16'd0; cmd_valid = 1'b1;
        watch(100);
        check("hold_no_early_accept", m_n, 1);
        send(3'd1, 8'd0, 16'd0);
        watch(100);
        check("edge_m_segs", m_n, 3);
        check("edge_m1_val", m_val[1], 1);
        check("edge_m1_len", m_len[1], 3);
        check("edge_dead_in_5_8", (m_len[2] >= 5 && m_len[2] <= 8), 1'b1);
        check("edge_d_segs", d_n, 1);
        check("edge_duty", d_val[0], 0);

        // Reset mid-command
        send(3'd2, 8'd255, 16'd5);
        repeat (12) @(negedge clk);
        check("midrst_pre_motor", motor_out, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_motor", motor_out, 4);
        check("midrst_duty", duty_cycle, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cmd_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_total, chk_fail);
        $finish;
    end
endmodule
